control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Per-slot instruction decoder for the VLIW datapath. Takes one slot's opcode,
//  addressing mode, destination field and source field and produces registered
//  write enables plus decoded operand controls.
//  Sits between the instruction-fetch/slot splitter and the register file,
//  ALU and data memory of its slot. One instance is used per VLIW slot.
// PARAMETERS
//  none. Field widths are fixed: opcode 3, dest 4, source 8.
// PORTS
//  clk             in   1  single clock, rising edge
//  rst_n           in   1  asynchronous active-low reset
//  OpCode          in   3  slot opcode
//  AddressingMode  in   1  0 = register source, 1 = immediate source
//  Destination     in   4  destination register index / store address register
//  Source          in   8  Source[3:0] = register index (mode 0); full byte = immediate (mode 1)
//  RegWrite        out  1  register-file write enable
//  MemWrite        out  1  data-memory write enable
//  AluOp           out  3  ALU function select (equals OpCode for non-STORE ops, else 3'b000)
//  ImmSel          out  1  1 = ALU operand B taken from Imm
//  DestReg         out  4  registered Destination
//  SrcReg          out  4  registered Source[3:0]
//  Imm             out  8  registered Source; 8'h00 when AddressingMode = 0
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain, posted decode. All outputs are flops updated on posedge clk.
//  - Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
//  - rst_n low clears every output to 0 immediately, without waiting for a clock edge.
//    Outputs stay 0 while rst_n is low.
//  - First decode occurs on the first rising edge after rst_n deasserts.
//  Opcode map
//  - 3'b100 STORE: MemWrite = 1, RegWrite = 0, AluOp = 3'b000.
//  - All other opcodes (000,001,010,011,101,110,111) are register-writing ALU/move ops:
//    RegWrite = 1, MemWrite = 0, AluOp = OpCode.
//  - RegWrite and MemWrite are never both 1 (mutually exclusive by construction).
//  Operand controls
//  - ImmSel = AddressingMode for every opcode, including STORE.
//  - DestReg, SrcReg and Imm register their fields unconditionally every cycle.
//  - Destination = 4'h0 receives no special treatment.
//  Boundary cases
//  - X or Z on OpCode must not propagate to the enables: decode with a full case
//    plus a default giving RegWrite = 1 and MemWrite = 0.
//  - Reset asserted mid-stream discards the in-flight decode. No state other than
//    the output flops exists.
// STRUCTURE
//  - Shared package vliw_pkg holds opcode localparams (OP_STORE = 3'b100, etc.)
//    and the field widths, so fetch and datapath agree with this block.
//  - Split into a combinational decode function/always block and an output
//    register stage. No sub-module is required; an optional cu_decode combinational
//    sub-module may hold the decode.
// TESTING  (10 ns clock; check outputs one cycle after applying inputs)
//  1 rst_n = 0 with OpCode = 3'b100 applied -> all outputs 0 immediately, with no clock edge.
//  2 Release reset, OpCode = 3'b000 -> RegWrite = 1, MemWrite = 0, AluOp = 000.
//  3 OpCode = 3'b100, Destination = 4'h5, Source = 8'h3A, AddressingMode = 0
//    -> RegWrite = 0, MemWrite = 1, DestReg = 5, SrcReg = A, Imm = 00, ImmSel = 0.
//  4 OpCode = 3'b001, AddressingMode = 1, Source = 8'hC7
//    -> RegWrite = 1, MemWrite = 0, AluOp = 001, ImmSel = 1, Imm = C7.
//  5 Sweep all 8 opcodes x both modes
//    -> MemWrite is 1 only for 100; RegWrite equals ~MemWrite.
//  6 Assert rst_n for 3 ns between clock edges during a STORE -> MemWrite drops at once
//    and stays 0 until the next edge after release.

Source files
------------

// File: rtl/vliw_pkg.sv
// vliw_pkg: opcode map, field widths and slot decode shared by fetch, decode and datapath.
package vliw_pkg;

    localparam int OP_W   = 3;
    localparam int DEST_W = 4;
    localparam int SRC_W  = 8;
    localparam int REG_W  = 4;

    localparam logic [OP_W-1:0] OP_MOV   = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b010;
    localparam logic [OP_W-1:0] OP_AND   = 3'b011;
    localparam logic [OP_W-1:0] OP_STORE = 3'b100;
    localparam logic [OP_W-1:0] OP_OR    = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b110;
    localparam logic [OP_W-1:0] OP_SHL   = 3'b111;

    typedef struct packed {
        logic            regWrite;
        logic            memWrite;
        logic [OP_W-1:0] aluOp;
    } decodeT;

    // Unknown opcodes fall into the register-writing default so the enables never go X.
    function automatic decodeT decodeOp(input logic [OP_W-1:0] op);
        decodeT d;
        d = '{regWrite: 1'b1, memWrite: 1'b0, aluOp: op};
        case (op)
            OP_STORE: d = '{regWrite: 1'b0, memWrite: 1'b1, aluOp: '0};
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL:
                d = '{regWrite: 1'b1, memWrite: 1'b0, aluOp: op};
            default: d = '{regWrite: 1'b1, memWrite: 1'b0, aluOp: op};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: per-slot VLIW decoder with registered enables and operand controls.
module control_unit
    import vliw_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   OpCode,
    input  logic              AddressingMode,
    input  logic [DEST_W-1:0] Destination,
    input  logic [SRC_W-1:0]  Source,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [OP_W-1:0]   AluOp,
    output logic              ImmSel,
    output logic [REG_W-1:0]  DestReg,
    output logic [REG_W-1:0]  SrcReg,
    output logic [SRC_W-1:0]  Imm
);

    decodeT dec;

    always_comb dec = decodeOp(OpCode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            MemWrite <= 1'b0;
            AluOp    <= '0;
            ImmSel   <= 1'b0;
            DestReg  <= '0;
            SrcReg   <= '0;
            Imm      <= '0;
        end else begin
            RegWrite <= dec.regWrite;
            MemWrite <= dec.memWrite;
            AluOp    <= dec.aluOp;
            ImmSel   <= AddressingMode;
            DestReg  <= Destination;
            SrcReg   <= Source[REG_W-1:0];
            Imm      <= AddressingMode ? Source : '0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed stimulus with an opcode-rule model compared every cycle plus literal checks.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] OpCode;
    logic       AddressingMode;
    logic [3:0] Destination;
    logic [7:0] Source;
    logic       RegWrite, MemWrite, ImmSel;
    logic [2:0] AluOp;
    logic [3:0] DestReg, SrcReg;
    logic [7:0] Imm;

    int nVec = 0;
    int nErr = 0;
    logic chkOn = 1'b0;
    logic [21:0] expV;
    logic [21:0] dutV;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .AddressingMode(AddressingMode),
        .Destination(Destination), .Source(Source), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AluOp(AluOp), .ImmSel(ImmSel), .DestReg(DestReg), .SrcReg(SrcReg), .Imm(Imm)
    );

    always #5 clk = ~clk;

    assign dutV = {RegWrite, MemWrite, AluOp, ImmSel, DestReg, SrcReg, Imm};

    // Expected output word straight from the opcode rules: only 100 stores, everything else writes a register.
    function automatic logic [21:0] model(input logic [2:0] op, input logic m,
                                          input logic [3:0] d, input logic [7:0] s);
        logic st;
        st = (op === 3'b100);
        return {!st, st, st ? 3'b000 : op, m, d, s[3:0], m ? s : 8'h00};
    endfunction

    always @(posedge clk or negedge rst_n)
        expV <= !rst_n ? 22'h0 : model(OpCode, AddressingMode, Destination, Source);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk)
        if (chkOn) chk("cycle", {10'b0, dutV}, {10'b0, expV});

    task automatic apply(input logic [2:0] op, input logic m, input logic [3:0] d, input logic [7:0] s);
        @(negedge clk);
        OpCode = op;
        AddressingMode = m;
        Destination = d;
        Source = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        OpCode = 3'b100;
        AddressingMode = 1'b1;
        Destination = 4'hF;
        Source = 8'hFF;
        #1 rst_n = 1'b0;
        #1 chk("reset_no_edge", {10'b0, dutV}, 32'h0);
        chkOn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("first_decode_store", {31'b0, MemWrite}, 32'h1);
        chk("first_decode_destreg", {28'b0, DestReg}, 32'hF);

        apply(3'b000, 1'b0, 4'h0, 8'h12);
        chk("mov_regwrite", {31'b0, RegWrite}, 32'h1);
        chk("mov_memwrite", {31'b0, MemWrite}, 32'h0);
        chk("mov_aluop", {29'b0, AluOp}, 32'h0);
        chk("dest_zero", {28'b0, DestReg}, 32'h0);

        apply(3'b100, 1'b0, 4'h5, 8'h3A);
        chk("store_regwrite", {31'b0, RegWrite}, 32'h0);
        chk("store_memwrite", {31'b0, MemWrite}, 32'h1);
        chk("store_destreg", {28'b0, DestReg}, 32'h5);
        chk("store_srcreg", {28'b0, SrcReg}, 32'hA);
        chk("store_imm", {24'b0, Imm}, 32'h00);
        chk("store_immsel", {31'b0, ImmSel}, 32'h0);

        apply(3'b001, 1'b1, 4'h2, 8'hC7);
        chk("addi_regwrite", {31'b0, RegWrite}, 32'h1);
        chk("addi_memwrite", {31'b0, MemWrite}, 32'h0);
        chk("addi_aluop", {29'b0, AluOp}, 32'h1);
        chk("addi_immsel", {31'b0, ImmSel}, 32'h1);
        chk("addi_imm", {24'b0, Imm}, 32'hC7);
        chk("addi_srcreg", {28'b0, SrcReg}, 32'h7);

        for (int o = 0; o < 8; o++)
            for (int m = 0; m < 2; m++) begin
                apply(3'(o), 1'(m), 4'(o + 8 * m), 8'(o * 37 + m * 91));
                chk("sweep_memwrite", {31'b0, MemWrite}, (o == 4) ? 32'h1 : 32'h0);
                chk("sweep_regwrite", {31'b0, RegWrite}, (o == 4) ? 32'h0 : 32'h1);
                chk("sweep_immsel", {31'b0, ImmSel}, 32'(m));
            end

        apply(3'bx, 1'b0, 4'h9, 8'h44);
        chk("xop_regwrite", {31'b0, RegWrite}, 32'h1);
        chk("xop_memwrite", {31'b0, MemWrite}, 32'h0);

        apply(3'b100, 1'b1, 4'h3, 8'h5E);
        chk("pre_pulse_memwrite", {31'b0, MemWrite}, 32'h1);
        rst_n = 1'b0;
        #1 chk("pulse_all_zero", {10'b0, dutV}, 32'h0);
        #2 rst_n = 1'b1;
        #4 chk("post_release_held", {31'b0, MemWrite}, 32'h0);
        @(posedge clk);
        #1 chk("after_edge_memwrite", {31'b0, MemWrite}, 32'h1);
        chk("after_edge_imm", {24'b0, Imm}, 32'h5E);

        apply(3'b110, 1'b1, 4'hE, 8'hA5);
        chk("xor_aluop", {29'b0, AluOp}, 32'h6);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
